// File: rtl/cache_bus_arbiter.sv
// Shares one downstream cache bus among NUM_REQ requesters, one burst at a time.
// Optional macro CACHE_ARB_RR_EN selects round-robin arbitration; otherwise fixed priority (index 0 first).
module cache_bus_arbiter #(
    parameter int NUM_REQ    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_REQ-1:0]              m_req_valid_i,
    output logic [NUM_REQ-1:0]              m_req_ready_o,
    input  logic [NUM_REQ-1:0]              m_req_write_i,
    input  logic [NUM_REQ*32-1:0]           m_req_addr_i,
    input  logic [NUM_REQ*LEN_WIDTH-1:0]    m_req_len_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   m_wdata_i,
    input  logic [NUM_REQ-1:0]              m_wvalid_i,
    input  logic [NUM_REQ-1:0]              m_wlast_i,
    output logic [NUM_REQ-1:0]              m_wready_o,
    output logic [NUM_REQ-1:0]              m_rvalid_o,
    output logic [NUM_REQ-1:0]              m_rlast_o,
    output logic [DATA_WIDTH-1:0]           m_rdata_o,
    output logic [NUM_REQ-1:0]              m_wdone_o,
    output logic                            s_req_valid_o,
    input  logic                            s_req_ready_i,
    output logic                            s_req_write_o,
    output logic [31:0]                     s_req_addr_o,
    output logic [LEN_WIDTH-1:0]            s_req_len_o,
    output logic [DATA_WIDTH-1:0]           s_wdata_o,
    output logic                            s_wvalid_o,
    output logic                            s_wlast_o,
    input  logic                            s_wready_i,
    input  logic                            s_rvalid_i,
    input  logic                            s_rlast_i,
    input  logic [DATA_WIDTH-1:0]           s_rdata_i,
    input  logic                            s_wdone_i,
    output logic [NUM_REQ-1:0]              grant_o,
    output logic                            busy_o,
    output logic                            proto_err_o
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_RDATA, S_WDATA, S_WRESP} state_e;

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       gnt_q, gnt_d;
    logic                   write_q, write_d;
    logic [31:0]            addr_q, addr_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   err_q, err_d;
    logic                   win_found;
    logic [IDX_W-1:0]       win_idx;
    logic                   beat, beat_last;

`ifdef CACHE_ARB_RR_EN
    logic [IDX_W-1:0] rr_q;

    // Pointer holds the last winner; reset value makes requester 0 the first pick.
    always_ff @(posedge clk) begin
        if (rst)
            rr_q <= IDX_W'(NUM_REQ - 1);
        else if (state_q == S_IDLE && win_found)
            rr_q <= win_idx;
    end
`endif

    always_comb begin
        int j;
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
`ifdef CACHE_ARB_RR_EN
            j = (int'(rr_q) + 1 + k) % NUM_REQ;
`else
            j = k;
`endif
            if (!win_found && m_req_valid_i[j]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(j);
            end
        end
    end

    always_comb begin
        beat      = 1'b0;
        beat_last = 1'b0;
        if (state_q == S_RDATA) begin
            beat      = s_rvalid_i;
            beat_last = s_rlast_i;
        end else if (state_q == S_WDATA) begin
            beat      = m_wvalid_i[gnt_q] & s_wready_i;
            beat_last = m_wlast_i[gnt_q];
        end
    end

    always_comb begin
        state_d       = state_q;
        gnt_d         = gnt_q;
        write_d       = write_q;
        addr_d        = addr_q;
        len_d         = len_q;
        cnt_d         = cnt_q;
        err_d         = err_q;
        m_req_ready_o = '0;
        m_wready_o    = '0;
        m_rvalid_o    = '0;
        m_rlast_o     = '0;
        m_rdata_o     = '0;
        m_wdone_o     = '0;
        s_req_valid_o = 1'b0;
        s_req_write_o = 1'b0;
        s_req_addr_o  = '0;
        s_req_len_o   = '0;
        s_wdata_o     = '0;
        s_wvalid_o    = 1'b0;
        s_wlast_o     = 1'b0;
        grant_o       = '0;

        if (state_q != S_IDLE) grant_o[gnt_q] = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (win_found && !rst) begin
                    m_req_ready_o[win_idx] = 1'b1;
                    gnt_d   = win_idx;
                    write_d = m_req_write_i[win_idx];
                    addr_d  = m_req_addr_i[win_idx*32 +: 32];
                    len_d   = m_req_len_i[win_idx*LEN_WIDTH +: LEN_WIDTH];
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                s_req_valid_o = 1'b1;
                s_req_write_o = write_q;
                s_req_addr_o  = addr_q;
                s_req_len_o   = len_q;
                if (s_req_ready_i) begin
                    cnt_d   = '0;
                    state_d = write_q ? S_WDATA : S_RDATA;
                end
            end
            S_RDATA: begin
                m_rvalid_o[gnt_q] = s_rvalid_i;
                m_rlast_o[gnt_q]  = s_rlast_i;
                m_rdata_o         = s_rdata_i;
                if (beat && beat_last) state_d = S_IDLE;
            end
            S_WDATA: begin
                s_wdata_o         = m_wdata_i[gnt_q*DATA_WIDTH +: DATA_WIDTH];
                s_wvalid_o        = m_wvalid_i[gnt_q];
                s_wlast_o         = m_wlast_i[gnt_q];
                m_wready_o[gnt_q] = s_wready_i;
                if (beat && beat_last) state_d = S_WRESP;
            end
            S_WRESP: begin
                if (s_wdone_i) begin
                    m_wdone_o[gnt_q] = 1'b1;
                    state_d          = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Length check: last must land exactly on beat len; counter saturates.
        if (beat) begin
            if (beat_last) begin
                if (cnt_q != len_q) err_d = 1'b1;
            end else if (cnt_q == len_q) begin
                err_d = 1'b1;
            end
            if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end
        if (s_rvalid_i && state_q != S_RDATA) err_d = 1'b1;
        if (s_wdone_i && state_q != S_WRESP) err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign busy_o      = (state_q != S_IDLE);
    assign proto_err_o = err_q;

endmodule

// File: doc/cache_bus_arbiter.md
Name: cache_bus_arbiter

Overview:
- Shares the single external cache bus between several cache requesters (e.g. icache refill, dcache refill/writeback, uncached LSU).
- Arbitrates, latches one transaction, sequences its address, data and response phases, then releases the bus.
- Sits between the cache modules and the AXI bridge; only one burst is outstanding at a time.

Parameters:
- NUM_REQ, 2, number of requesters; index 0 is the dcache.
- DATA_WIDTH, 32, width of a data beat.
- LEN_WIDTH, 8, width of the burst-length field; the field value is the number of beats minus 1.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- m_req_valid_i  in  NUM_REQ  per-requester request valid
- m_req_ready_o  out  NUM_REQ  one-hot; pulses for exactly 1 cycle when that request is accepted (latched)
- m_req_write_i  in  NUM_REQ  1 = write burst
- m_req_addr_i  in  NUM_REQ*32  burst start address
- m_req_len_i  in  NUM_REQ*LEN_WIDTH  beats minus 1
- m_wdata_i  in  NUM_REQ*DATA_WIDTH  write beat data
- m_wvalid_i  in  NUM_REQ  write beat valid
- m_wlast_i  in  NUM_REQ  final write beat
- m_wready_o  out  NUM_REQ  write beat accepted (granted requester only)
- m_rvalid_o  out  NUM_REQ  read beat valid, routed to the granted requester only
- m_rlast_o  out  NUM_REQ  final read beat
- m_rdata_o  out  DATA_WIDTH  read data, broadcast to all requesters
- m_wdone_o  out  NUM_REQ  write completion pulse
- s_req_valid_o  out  1  downstream request valid
- s_req_ready_i  in  1  downstream request accepted
- s_req_write_o  out  1  downstream write flag
- s_req_addr_o  out  32  downstream address
- s_req_len_o  out  LEN_WIDTH  downstream length
- s_wdata_o  out  DATA_WIDTH  downstream write data
- s_wvalid_o  out  1  downstream write valid
- s_wlast_o  out  1  downstream write last
- s_wready_i  in  1  downstream write ready
- s_rvalid_i  in  1  downstream read beat valid
- s_rlast_i  in  1  downstream read beat last
- s_rdata_i  in  DATA_WIDTH  downstream read data
- s_wdone_i  in  1  downstream write response
- grant_o  out  NUM_REQ  one-hot current owner; 0 in IDLE
- busy_o  out  1  FSM not in IDLE
- proto_err_o  out  1  sticky protocol-error flag

Behaviour:
- States: IDLE, ADDR, RDATA, WDATA, WRESP.
- Reset (rst=1 at a clk edge):
  - FSM goes to IDLE; RR pointer is set so that requester 0 wins next.
  - All outputs 0, including proto_err_o.
  - Reset mid-burst abandons the burst with no completion pulses; the downstream is reset in the same domain.
- IDLE:
  - If any m_req_valid_i is set, pick a winner, pulse its m_req_ready_o in that cycle, and latch write/addr/len and winner index.
  - Go to ADDR next cycle.
  - A requester must hold its fields stable while valid and not ready.
- ADDR:
  - s_req_valid_o=1 with the latched fields; grant_o is one-hot.
  - On s_req_valid_o & s_req_ready_i: go to WDATA if write, else RDATA. Beat counter cleared to 0.
  - Accept latency: request in cycle N, s_req_valid_o in cycle N+1.
- RDATA:
  - Combinational pass-through: m_rvalid_o[g]=s_rvalid_i, m_rlast_o[g]=s_rlast_i, m_rdata_o=s_rdata_i. Zero added latency.
  - Every beat increments the counter.
  - On a beat with s_rlast_i: go to IDLE.
  - If counter != latched len on the last beat, or counter reaches len without last, set proto_err_o.
- WDATA:
  - s_wdata_o/s_wvalid_o/s_wlast_o are muxed from requester g.
  - m_wready_o[g]=s_wready_i; all other m_wready_o bits are 0.
  - Beat counting and the length check mirror RDATA.
  - On an accepted beat with wlast: go to WRESP.
- WRESP:
  - On s_wdone_i: m_wdone_o[g] pulses in the same cycle; go to IDLE.
- The bus is returned to IDLE for 1 cycle between transactions, so back-to-back bursts are spaced by at least one idle cycle.
- Downstream beats arriving outside RDATA/WRESP are ignored and set proto_err_o.
- LEN arithmetic: the counter is LEN_WIDTH bits wide and never wraps. len=0 means a single beat.
- RR pointer updates to the winner index at accept time.

Optional Feature:
- Macro: CACHE_ARB_RR_EN.
- Defined: round-robin. The search starts at last winner + 1, modulo NUM_REQ.
- Undefined: fixed priority; the lowest index wins, so dcache wins over icache. The RR pointer is not implemented.

Test Plan:
- Single read: req1 valid, addr=0x1C000000, len=3 -> m_req_ready_o=2'b10 in cycle 0, s_req_valid_o in cycle 1, 4 beats routed to m_rvalid_o[1] only, busy_o=0 the cycle after rlast.
- Simultaneous req0+req1 held continuously, RR enabled -> grants alternate 0,1,0,1 across 4 bursts; with the macro undefined, req0 wins every time.
- Write len=1 to 0x80: beats D0,D1 with s_wready_i toggling 1,0,1 -> s_wvalid_o stalls correctly, WRESP entered after D1, m_wdone_o[0] pulses on s_wdone_i.
- Read len=3 with s_rlast_i asserted on beat 2 -> proto_err_o=1 and stays 1 until rst.
- rst asserted in RDATA after 1 beat -> next cycle busy_o=0, grant_o=0, proto_err_o=0; a new req1 is accepted the following cycle.
